// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared counter/period, edge- or center-aligned counting,
// and double-buffered duty/period/mode that only take effect at period boundaries.
module pwm_multi #(
    parameter int WIDTH    = 11,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [WIDTH-1:0]          period,
    input  logic                      center_mode,
    input  logic [CHANNELS-1:0]       duty_wr,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    output logic [CHANNELS-1:0]       PWM_sig,
    output logic                      cycle_start
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]                 cnt_q, cnt_d;
    logic                             dir_q, dir_d;   // 1 = counting down
    logic [CHANNELS-1:0][WIDTH-1:0]   shadow_q, shadow_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   active_duty_q, active_duty_d;
    logic [WIDTH-1:0]                 active_period_q, active_period_d;
    logic                             active_mode_q, active_mode_d;
    logic [CHANNELS-1:0]              pwm_q, pwm_d;
    logic                             cycle_start_q, cycle_start_d;
    logic                             load;

    // Counter sequencing; 'load' marks the edge where the count wraps to 0 (or en is low).
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        load  = 1'b0;
        if (!en) begin
            load = 1'b1;
        end else if (!active_mode_q || active_period_q == '0) begin
            if (cnt_q >= active_period_q) load = 1'b1;
            else                          cnt_d = cnt_q + ONE;
        end else if (!dir_q) begin
            if (cnt_q >= active_period_q) begin
                if (active_period_q == ONE) begin
                    load = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                    dir_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            if (cnt_q <= ONE) load = 1'b1;
            else              cnt_d = cnt_q - ONE;
        end
        if (load) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end
    end

    // A write coinciding with the wrap reaches the active register directly via shadow_d.
    always_comb begin
        shadow_d      = shadow_q;
        active_duty_d = active_duty_q;
        pwm_d         = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (duty_wr[i]) shadow_d[i] = duty_in[i*WIDTH +: WIDTH];
            if (load)       active_duty_d[i] = shadow_d[i];
            pwm_d[i] = en && (cnt_q < active_duty_q[i]);
        end
        active_period_d = load ? period      : active_period_q;
        active_mode_d   = load ? center_mode : active_mode_q;
        cycle_start_d   = en && (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= '0;
            dir_q           <= 1'b0;
            shadow_q        <= '0;
            active_duty_q   <= '0;
            active_period_q <= '0;
            active_mode_q   <= 1'b0;
            pwm_q           <= '0;
            cycle_start_q   <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            dir_q           <= dir_d;
            shadow_q        <= shadow_d;
            active_duty_q   <= active_duty_d;
            active_period_q <= active_period_d;
            active_mode_q   <= active_mode_d;
            pwm_q           <= pwm_d;
            cycle_start_q   <= cycle_start_d;
        end
    end

    assign PWM_sig     = pwm_q;
    assign cycle_start = cycle_start_q;

endmodule
